// File: rtl/gyro_tilt_integrator_if.sv
// gyro_tilt_integrator_if -- sample/tilt handshake bundle between the gyro front end and the integrator.
// Rev 1.0
`default_nettype none

interface gyro_tilt_integrator_if #(
  parameter int N_CH  = 3,
  parameter int IN_W  = 16,
  parameter int OUT_W = 16
);
  logic [N_CH*IN_W-1:0]  rate_in;
  logic                  rate_valid;
  logic                  rate_ready;
  logic                  cal_start;
  logic                  zero;
  logic [N_CH*OUT_W-1:0] tilt_out;
  logic                  tilt_valid;
  logic                  cal_done;
  logic [N_CH-1:0]       sat_flag;

  modport master (
    output rate_in, rate_valid, cal_start, zero,
    input  rate_ready, tilt_out, tilt_valid, cal_done, sat_flag
  );

  modport slave (
    input  rate_in, rate_valid, cal_start, zero,
    output rate_ready, tilt_out, tilt_valid, cal_done, sat_flag
  );
endinterface

`default_nettype wire

// File: rtl/gyro_tilt_integrator.sv
// gyro_tilt_integrator -- multi-channel rate-to-tilt integrator with bias calibration and zeroing.
// Rev 1.0. Define GYRO_TILT_SAT_EN for saturating accumulators with sticky sat_flag.
`default_nettype none

module gyro_tilt_integrator #(
  parameter int          N_CH      = 3,
  parameter int          IN_W      = 16,
  parameter int          ACC_W     = 32,
  parameter int          OUT_W     = 16,
  parameter int          OUT_SHIFT = 0,
  parameter int unsigned DT_MUL    = 10,
  parameter int          CAL_LOG2  = 2
) (
  input  logic                    CLK,
  input  logic                    RST,
  gyro_tilt_integrator_if.slave   bus
);

  localparam int BS_W  = IN_W + CAL_LOG2;
  localparam int CNT_W = (CAL_LOG2 > 0) ? CAL_LOG2 : 1;
  localparam logic [CNT_W-1:0]       CAL_LAST = CNT_W'(2**CAL_LOG2 - 1);
  localparam logic signed [ACC_W-1:0] DT_A    = ACC_W'(DT_MUL);

  typedef enum logic [1:0] {
    S_RUN = 2'd0,
    S_CAL = 2'd1,
    S_FIN = 2'd2
  } state_t;

  state_t                  state_q;
  logic                    rate_ready_q;
  logic                    tilt_valid_q;
  logic                    cal_done_q;
  logic [CNT_W-1:0]        cnt_q;
  logic signed [ACC_W-1:0] acc_q    [N_CH];
  logic signed [IN_W-1:0]  bias_q   [N_CH];
  logic signed [BS_W-1:0]  bsum_q   [N_CH];

  logic signed [ACC_W-1:0] acc_d    [N_CH];
  logic signed [BS_W-1:0]  bsum_d   [N_CH];
  logic signed [IN_W-1:0]  bias_d   [N_CH];
  logic                    accept;
  logic [N_CH*OUT_W-1:0]   tilt_w;

`ifdef GYRO_TILT_SAT_EN
  logic [N_CH-1:0]         sat_q;
  logic [N_CH-1:0]         clip_hit;
`endif

  assign accept = bus.rate_valid & rate_ready_q;

  generate
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
      logic signed [IN_W-1:0]  rate;
      logic signed [IN_W:0]    diff;
      logic signed [ACC_W-1:0] prod;

      assign rate = bus.rate_in[i*IN_W +: IN_W];
      // One extra bit so rate-bias cannot overflow before scaling.
      assign diff = {rate[IN_W-1], rate} - {bias_q[i][IN_W-1], bias_q[i]};
      assign prod = ACC_W'(diff) * DT_A;

      assign bsum_d[i] = bsum_q[i] + BS_W'(rate);
      assign bias_d[i] = IN_W'(bsum_q[i] >>> CAL_LOG2);

`ifdef GYRO_TILT_SAT_EN
      logic signed [ACC_W:0] sum;
      assign sum         = {acc_q[i][ACC_W-1], acc_q[i]} + {prod[ACC_W-1], prod};
      // Overflow shows as disagreement between the two top bits of the widened sum.
      assign clip_hit[i] = sum[ACC_W] ^ sum[ACC_W-1];
      assign acc_d[i]    = !clip_hit[i] ? sum[ACC_W-1:0]
                         : (sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                       : {1'b0, {(ACC_W-1){1'b1}}});
`else
      assign acc_d[i]    = acc_q[i] + prod;
`endif
    end
  endgenerate

  always_comb begin
    tilt_w = '0;
    for (int i = 0; i < N_CH; i++) begin
      tilt_w[i*OUT_W +: OUT_W] = acc_q[i][OUT_SHIFT +: OUT_W];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= S_RUN;
      rate_ready_q <= 1'b1;
      tilt_valid_q <= 1'b0;
      cal_done_q   <= 1'b0;
      cnt_q        <= '0;
      for (int i = 0; i < N_CH; i++) begin
        acc_q[i]  <= '0;
        bias_q[i] <= '0;
        bsum_q[i] <= '0;
      end
`ifdef GYRO_TILT_SAT_EN
      sat_q <= '0;
`endif
    end else begin
      tilt_valid_q <= 1'b0;
      cal_done_q   <= 1'b0;
      case (state_q)
        S_RUN: begin
          if (bus.cal_start) begin
            state_q <= S_CAL;
            cnt_q   <= '0;
            for (int i = 0; i < N_CH; i++) bsum_q[i] <= '0;
          end
          // zero and cal_start both swallow a same-cycle sample.
          if (bus.zero) begin
            for (int i = 0; i < N_CH; i++) acc_q[i] <= '0;
          end else if (accept && !bus.cal_start) begin
            for (int i = 0; i < N_CH; i++) acc_q[i] <= acc_d[i];
            tilt_valid_q <= 1'b1;
`ifdef GYRO_TILT_SAT_EN
            sat_q <= sat_q | clip_hit;
`endif
          end
        end

        S_CAL: begin
          if (bus.cal_start) begin
            cnt_q <= '0;
            for (int i = 0; i < N_CH; i++) bsum_q[i] <= '0;
          end else if (accept) begin
            for (int i = 0; i < N_CH; i++) bsum_q[i] <= bsum_d[i];
            if (cnt_q == CAL_LAST) begin
              state_q      <= S_FIN;
              rate_ready_q <= 1'b0;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end

        S_FIN: begin
          for (int i = 0; i < N_CH; i++) begin
            bias_q[i] <= bias_d[i];
            acc_q[i]  <= '0;
          end
`ifdef GYRO_TILT_SAT_EN
          sat_q <= '0;
`endif
          cal_done_q   <= 1'b1;
          rate_ready_q <= 1'b1;
          state_q      <= S_RUN;
        end

        default: begin
          state_q      <= S_RUN;
          rate_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.rate_ready = rate_ready_q;
  assign bus.tilt_out   = tilt_w;
  assign bus.tilt_valid = tilt_valid_q;
  assign bus.cal_done   = cal_done_q;
`ifdef GYRO_TILT_SAT_EN
  assign bus.sat_flag   = sat_q;
`else
  assign bus.sat_flag   = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_gyro_tilt_integrator.sv
// tb_gyro_tilt_integrator -- directed self-checking bench for gyro_tilt_integrator.
// Rev 1.0
`default_nettype none

module tb_gyro_tilt_integrator;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 CLK = ~CLK;

  gyro_tilt_integrator_if #(.N_CH(3), .IN_W(16), .OUT_W(16)) i1 ();
  gyro_tilt_integrator_if #(.N_CH(3), .IN_W(16), .OUT_W(16)) i2 ();

  gyro_tilt_integrator u_dut (
    .CLK (CLK),
    .RST (RST),
    .bus (i1.slave)
  );

  gyro_tilt_integrator #(.ACC_W(16), .OUT_W(16), .DT_MUL(1)) u_dut16 (
    .CLK (CLK),
    .RST (RST),
    .bus (i2.slave)
  );

`ifdef GYRO_TILT_SAT_EN
  localparam logic signed [31:0] EXP_T4_X   = 32767;
  localparam logic signed [31:0] EXP_T4_SAT = 1;
`else
  localparam logic signed [31:0] EXP_T4_X   = -2;
  localparam logic signed [31:0] EXP_T4_SAT = 0;
`endif

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set1(input logic signed [15:0] x, input logic signed [15:0] y,
                      input logic signed [15:0] z, input logic v);
    i1.rate_in    = {z, y, x};
    i1.rate_valid = v;
  endtask

  function automatic logic signed [15:0] t1(input int c);
    logic [47:0] t;
    t = i1.tilt_out;
    return t[c*16 +: 16];
  endfunction

  function automatic logic signed [15:0] t2(input int c);
    logic [47:0] t;
    t = i2.tilt_out;
    return t[c*16 +: 16];
  endfunction

  initial begin
    i1.rate_in = '0; i1.rate_valid = 1'b0; i1.cal_start = 1'b0; i1.zero = 1'b0;
    i2.rate_in = '0; i2.rate_valid = 1'b0; i2.cal_start = 1'b0; i2.zero = 1'b0;

    repeat (3) @(posedge CLK);
    #1;
    chk("rst_tilt",       $signed(i1.tilt_out), 0);
    chk("rst_tilt_valid", i1.tilt_valid, 0);
    chk("rst_cal_done",   i1.cal_done, 0);
    chk("rst_rate_ready", i1.rate_ready, 1);
    chk("rst_sat",        i1.sat_flag, 0);
    RST = 1'b0;

    // Back-to-back samples (5,-3,0)
    set1(5, -3, 0, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("b2b_valid", i1.tilt_valid, 1);
      chk("b2b_x", t1(0), 50 * k);
    end
    chk("b2b_y", t1(1), -120);
    chk("b2b_z", t1(2), 0);

    // zero wins over a same-cycle sample
    i1.zero = 1'b1;
    set1(5, 0, 0, 1'b1);
    tick();
    chk("zero_x", t1(0), 0);
    chk("zero_y", t1(1), 0);
    chk("zero_valid", i1.tilt_valid, 0);
    i1.zero = 1'b0;
    set1(1, 0, 0, 1'b1);
    tick();
    chk("post_zero_x", t1(0), 10);
    chk("post_zero_valid", i1.tilt_valid, 1);
    i1.rate_valid = 1'b0;
    tick();
    chk("valid_pulse_end", i1.tilt_valid, 0);

    // Calibration: same-cycle sample with cal_start is dropped
    i1.cal_start = 1'b1;
    set1(100, 0, 0, 1'b1);
    tick();
    chk("calstart_valid", i1.tilt_valid, 0);
    chk("calstart_x", t1(0), 10);
    chk("cal_ready", i1.rate_ready, 1);
    i1.cal_start = 1'b0;
    set1(2, 0, 0, 1'b1); tick();
    chk("cal_no_valid", i1.tilt_valid, 0);
    set1(3, 0, 0, 1'b1); tick();
    chk("cal_no_done", i1.cal_done, 0);
    set1(2, 0, 0, 1'b1); tick();
    chk("cal_x_hold", t1(0), 10);
    set1(1, 0, 0, 1'b1); tick();
    chk("fin_ready", i1.rate_ready, 0);
    chk("fin_done_early", i1.cal_done, 0);
    set1(50, 0, 0, 1'b1); tick();
    chk("fin_done", i1.cal_done, 1);
    chk("fin_ready_back", i1.rate_ready, 1);
    chk("fin_acc_clr", t1(0), 0);
    chk("fin_no_valid", i1.tilt_valid, 0);
    set1(7, 0, 0, 1'b1); tick();
    chk("bias2_x", t1(0), 50);
    chk("bias2_done_end", i1.cal_done, 0);
    i1.rate_valid = 1'b0;

    // Reset in the middle of calibration
    i1.cal_start = 1'b1; tick();
    i1.cal_start = 1'b0;
    set1(4, 4, 4, 1'b1); tick(); tick();
    i1.rate_valid = 1'b0;
    RST = 1'b1; tick();
    RST = 1'b0;
    chk("midrst_ready", i1.rate_ready, 1);
    chk("midrst_done", i1.cal_done, 0);
    chk("midrst_x", t1(0), 0);
    tick();
    chk("midrst_done2", i1.cal_done, 0);
    set1(3, 0, 0, 1'b1); tick();
    chk("midrst_bias0_x", t1(0), 30);
    chk("midrst_valid", i1.tilt_valid, 1);
    i1.rate_valid = 1'b0;

    // Restart calibration after 3 samples
    i1.cal_start = 1'b1; tick();
    i1.cal_start = 1'b0;
    set1(1, 1, 1, 1'b1);
    repeat (3) tick();
    i1.rate_valid = 1'b0;
    i1.cal_start = 1'b1; tick();
    i1.cal_start = 1'b0;
    set1(8, 0, 0, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("recal_ready", i1.rate_ready, (k == 4) ? 0 : 1);
      chk("recal_done", i1.cal_done, 0);
    end
    i1.rate_valid = 1'b0;
    tick();
    chk("recal_done_pulse", i1.cal_done, 1);
    tick();
    chk("recal_done_once", i1.cal_done, 0);
    set1(8, 0, 0, 1'b1); tick();
    chk("bias8_x", t1(0), 0);
    chk("bias8_valid", i1.tilt_valid, 1);
    set1(9, 0, 0, 1'b1); tick();
    chk("bias8_x2", t1(0), 10);
    chk("sat_default", i1.sat_flag, 0);
    i1.rate_valid = 1'b0;

    // 16-bit accumulator overflow
    i2.rate_in    = {16'sd0, 16'sd0, 16'sd32767};
    i2.rate_valid = 1'b1;
    tick();
    chk("ovf_first_x", t2(0), 32767);
    chk("ovf_first_sat", i2.sat_flag, 0);
    tick();
    chk("ovf_x", t2(0), EXP_T4_X);
    chk("ovf_sat", i2.sat_flag, EXP_T4_SAT);
    chk("ovf_y", t2(1), 0);
    i2.rate_valid = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
